mem_access_stage: RTL and testbench

- Memory-access stage of the LC3 pipeline. Sits directly downstream of the pipeline controller and consumes its 2-bit mem_state command.
- Runs the data-memory request/complete handshake for four operation types: load, store, indirect load and indirect store.
- Registers all memory-side address, data and control outputs.
- Returns the loaded word to writeback and reports completion, busy and error status.

---
 rtl/mem_access_stage_if.sv | 20 ++
 rtl/mem_access_stage.sv | 152 +++++++++++++++
 tb/tb_mem_access_stage.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// Data-memory port of the LC3 memory-access stage: request/complete handshake
// plus address, write data and read data.
interface mem_access_stage_if;
  logic [15:0] Data_addr;
  logic [15:0] Data_dout;
  logic        Data_rd;
  logic        Data_req;
  logic        complete_data;
  logic [15:0] Data_din;

  modport master (
    output Data_addr, Data_dout, Data_rd, Data_req,
    input  complete_data, Data_din
  );

  modport slave (
    input  Data_addr, Data_dout, Data_rd, Data_req,
    output complete_data, Data_din
  );
endinterface

// File: rtl/mem_access_stage.sv
// LC3 memory-access stage: runs load, store, indirect load and indirect store
// over the data-memory handshake with a request timeout and sticky error flag.
module mem_access_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          mem_state,
  input  logic [15:0]         M_Addr,
  input  logic [15:0]         M_Data,
  mem_access_stage_if.master  dmem,
  output logic [15:0]         memout,
  output logic                mem_done,
  output logic                mem_busy,
  output logic                mem_err
);

  typedef enum logic [2:0] {IDLE, IND, RD, WR, DONE} state_t;

  localparam logic [1:0] CMD_READ  = 2'd0;
  localparam logic [1:0] CMD_IND   = 2'd1;
  localparam logic [1:0] CMD_WRITE = 2'd2;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [15:0]      addr_reg, addr_next;
  logic [15:0]      dout_reg, dout_next;
  logic             rd_reg, rd_next;
  logic             req_reg, req_next;
  logic [15:0]      memout_reg, memout_next;
  logic             done_reg, done_next;
  logic             err_reg, err_next;

  logic in_access;
  logic complete;
  logic timeout_hit;

  // complete_data only counts while a request is actually on the bus.
  assign in_access   = (state_reg == IND) || (state_reg == RD) || (state_reg == WR);
  assign complete    = in_access && dmem.complete_data;
  assign timeout_hit = in_access && !dmem.complete_data
                       && (cnt_reg == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      addr_reg   <= '0;
      dout_reg   <= '0;
      rd_reg     <= 1'b1;
      req_reg    <= 1'b0;
      memout_reg <= '0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      addr_reg   <= addr_next;
      dout_reg   <= dout_next;
      rd_reg     <= rd_next;
      req_reg    <= req_next;
      memout_reg <= memout_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        case (mem_state)
          CMD_READ:  state_next = RD;
          CMD_IND:   state_next = IND;
          CMD_WRITE: state_next = WR;
          default:   state_next = IDLE;
        endcase
      end
      IND: begin
        if (complete) begin
          case (mem_state)
            CMD_READ:  state_next = RD;
            CMD_WRITE: state_next = WR;
            default:   state_next = IDLE;
          endcase
        end else if (timeout_hit) begin
          state_next = IDLE;
        end
      end
      RD, WR: begin
        if (complete)         state_next = DONE;
        else if (timeout_hit) state_next = IDLE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    addr_next   = addr_reg;
    dout_next   = dout_reg;
    rd_next     = rd_reg;
    memout_next = memout_reg;
    err_next    = err_reg;
    cnt_next    = '0;

    if (state_next == state_reg && in_access)
      cnt_next = cnt_reg + CNT_W'(1);

    case (state_reg)
      IDLE: begin
        if (mem_state != 2'd3) begin
          addr_next = M_Addr;
          rd_next   = (mem_state != CMD_WRITE);
          err_next  = 1'b0;
          if (mem_state != CMD_READ)
            dout_next = M_Data;
        end
      end
      IND: begin
        if (complete) begin
          // The fetched word is the pointer for the follow-on access.
          addr_next = dmem.Data_din;
          if (mem_state == CMD_READ)       rd_next  = 1'b1;
          else if (mem_state == CMD_WRITE) rd_next  = 1'b0;
          else                             err_next = 1'b1;
        end
      end
      RD: begin
        if (complete) memout_next = dmem.Data_din;
      end
      DONE:    rd_next = 1'b1;
      default: ;
    endcase

    if (timeout_hit) err_next = 1'b1;
  end

  assign req_next  = (state_next == IND) || (state_next == RD) || (state_next == WR);
  assign done_next = (state_next == DONE);

  assign dmem.Data_addr = addr_reg;
  assign dmem.Data_dout = dout_reg;
  assign dmem.Data_rd   = rd_reg;
  assign dmem.Data_req  = req_reg;
  assign memout         = memout_reg;
  assign mem_done       = done_reg;
  assign mem_err        = err_reg;
  assign mem_busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: load, store, indirect ops, timeout,
// ignored completes and mid-access reset, with hand-computed expectations.
module tb_mem_access_stage;
  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  mem_state;
  logic [15:0] M_Addr, M_Data;
  logic [15:0] memout;
  logic        mem_done, mem_busy, mem_err;
  int          n_cmp = 0;
  int          n_err = 0;

  mem_access_stage_if dmem ();

  mem_access_stage #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clock     (clock),
    .reset     (reset),
    .mem_state (mem_state),
    .M_Addr    (M_Addr),
    .M_Data    (M_Data),
    .dmem      (dmem.master),
    .memout    (memout),
    .mem_done  (mem_done),
    .mem_busy  (mem_busy),
    .mem_err   (mem_err)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"},   dmem.Data_addr, 16'h0000);
    chk({tag, "_dout"},   dmem.Data_dout, 16'h0000);
    chk({tag, "_rd"},     16'(dmem.Data_rd), 16'd1);
    chk({tag, "_req"},    16'(dmem.Data_req), 16'd0);
    chk({tag, "_memout"}, memout, 16'h0000);
    chk({tag, "_done"},   16'(mem_done), 16'd0);
    chk({tag, "_busy"},   16'(mem_busy), 16'd0);
    chk({tag, "_err"},    16'(mem_err), 16'd0);
  endtask

  initial begin
    reset = 1'b1; mem_state = 2'd3; M_Addr = '0; M_Data = '0;
    dmem.complete_data = 1'b0; dmem.Data_din = '0;
    step(); step();
    chk_reset_vals("rst");
    reset = 1'b0;

    // complete_data in IDLE is ignored
    dmem.complete_data = 1'b1; dmem.Data_din = 16'hBEEF;
    step();
    chk("idle_cd_busy", 16'(mem_busy), 16'd0);
    chk("idle_cd_req",  16'(dmem.Data_req), 16'd0);

    // Load 0x3005, complete held high across acceptance, first request cycle
    mem_state = 2'd0; M_Addr = 16'h3005;
    step();
    mem_state = 2'd3; M_Addr = 16'hFFFF;
    chk("ld_addr", dmem.Data_addr, 16'h3005);
    chk("ld_rd",   16'(dmem.Data_rd), 16'd1);
    chk("ld_req",  16'(dmem.Data_req), 16'd1);
    chk("ld_done_acc", 16'(mem_done), 16'd0);
    step();
    dmem.complete_data = 1'b0;
    chk("ld_done",   16'(mem_done), 16'd1);
    chk("ld_req_off", 16'(dmem.Data_req), 16'd0);
    chk("ld_memout", memout, 16'hBEEF);
    step();
    chk("ld_done_pulse", 16'(mem_done), 16'd0);
    chk("ld_idle", 16'(mem_busy), 16'd0);

    // Store 0x1234 -> 0x3010, complete after 4 extra request cycles
    mem_state = 2'd2; M_Addr = 16'h3010; M_Data = 16'h1234;
    step();
    mem_state = 2'd0; M_Addr = 16'hFFFF; M_Data = 16'hFFFF;
    chk("st_addr", dmem.Data_addr, 16'h3010);
    chk("st_dout", dmem.Data_dout, 16'h1234);
    chk("st_rd",   16'(dmem.Data_rd), 16'd0);
    chk("st_req",  16'(dmem.Data_req), 16'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("st_req_hold", 16'(dmem.Data_req), 16'd1);
      chk("st_rd_hold",  16'(dmem.Data_rd), 16'd0);
      chk("st_dout_hold", dmem.Data_dout, 16'h1234);
    end
    dmem.complete_data = 1'b1;
    step();
    dmem.complete_data = 1'b0; mem_state = 2'd3;
    chk("st_done",   16'(mem_done), 16'd1);
    chk("st_req_off", 16'(dmem.Data_req), 16'd0);
    chk("st_memout", memout, 16'hBEEF);
    step();
    chk("st_done_pulse", 16'(mem_done), 16'd0);
    chk("st_rd_back", 16'(dmem.Data_rd), 16'd1);

    // Indirect load: pointer 0x4000, data 0x00AA
    mem_state = 2'd1; M_Addr = 16'h3020; M_Data = 16'h0000;
    step();
    chk("il_addr1", dmem.Data_addr, 16'h3020);
    chk("il_req1",  16'(dmem.Data_req), 16'd1);
    dmem.complete_data = 1'b1; dmem.Data_din = 16'h4000; mem_state = 2'd0;
    step();
    chk("il_addr2", dmem.Data_addr, 16'h4000);
    chk("il_req2",  16'(dmem.Data_req), 16'd1);
    chk("il_rd2",   16'(dmem.Data_rd), 16'd1);
    chk("il_nodone", 16'(mem_done), 16'd0);
    mem_state = 2'd3; dmem.Data_din = 16'h00AA;
    step();
    dmem.complete_data = 1'b0;
    chk("il_done",   16'(mem_done), 16'd1);
    chk("il_memout", memout, 16'h00AA);
    step();
    chk("il_done_pulse", 16'(mem_done), 16'd0);

    // Indirect store: pointer 0x4000, write 0x5555
    mem_state = 2'd1; M_Addr = 16'h3020; M_Data = 16'h5555;
    step();
    dmem.complete_data = 1'b1; dmem.Data_din = 16'h4000; mem_state = 2'd2;
    step();
    chk("is_addr2", dmem.Data_addr, 16'h4000);
    chk("is_dout",  dmem.Data_dout, 16'h5555);
    chk("is_rd",    16'(dmem.Data_rd), 16'd0);
    chk("is_req",   16'(dmem.Data_req), 16'd1);
    mem_state = 2'd3; dmem.Data_din = 16'h1111;
    step();
    dmem.complete_data = 1'b0;
    chk("is_done",   16'(mem_done), 16'd1);
    chk("is_memout", memout, 16'h00AA);
    step();

    // Timeout: read never completed; abort after 16 request cycles
    mem_state = 2'd0; M_Addr = 16'h3100;
    step();
    mem_state = 2'd3;
    for (int i = 1; i < 16; i++) begin
      step();
      chk("to_req_hold", 16'(dmem.Data_req), 16'd1);
      chk("to_err_low",  16'(mem_err), 16'd0);
    end
    step();
    chk("to_err",    16'(mem_err), 16'd1);
    chk("to_req",    16'(dmem.Data_req), 16'd0);
    chk("to_done",   16'(mem_done), 16'd0);
    chk("to_busy",   16'(mem_busy), 16'd0);
    chk("to_memout", memout, 16'h00AA);

    // Complete on the timeout cycle wins; acceptance clears mem_err
    mem_state = 2'd0; M_Addr = 16'h3180; dmem.Data_din = 16'h0C0C;
    step();
    mem_state = 2'd3;
    chk("tw_err_clr", 16'(mem_err), 16'd0);
    for (int i = 1; i < 16; i++) step();
    dmem.complete_data = 1'b1;
    step();
    dmem.complete_data = 1'b0;
    chk("tw_done",   16'(mem_done), 16'd1);
    chk("tw_err",    16'(mem_err), 16'd0);
    chk("tw_memout", memout, 16'h0C0C);
    step();

    // Indirect with an idle command on the pointer return is an error
    mem_state = 2'd1; M_Addr = 16'h3300;
    step();
    mem_state = 2'd3; dmem.complete_data = 1'b1; dmem.Data_din = 16'h4444;
    step();
    dmem.complete_data = 1'b0;
    chk("ie_err",  16'(mem_err), 16'd1);
    chk("ie_busy", 16'(mem_busy), 16'd0);
    chk("ie_done", 16'(mem_done), 16'd0);

    // Reset in the middle of a write
    mem_state = 2'd2; M_Addr = 16'h3200; M_Data = 16'h7777;
    step();
    mem_state = 2'd3;
    chk("wr_err_clr", 16'(mem_err), 16'd0);
    chk("wr_req",     16'(dmem.Data_req), 16'd1);
    reset = 1'b1;
    step();
    chk_reset_vals("midrst");
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
